sprite_blitter: RTL and testbench

SPRITE_BLITTER -- requirements
Module: sprite_blitter

---
 rtl/sprite_blitter_pkg.sv | 16 +
 rtl/sprite_blitter_if.sv | 24 ++
 rtl/sprite_blit_datapath.sv | 118 +++++++++++
 rtl/sprite_blitter.sv | 111 +++++++++++
 tb/tb_sprite_blitter.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/sprite_blitter_pkg.sv
// rtl/sprite_blitter_pkg.sv - shared graphics draw-module definitions
package sprite_blitter_pkg;

    // Draw-module controller states shared by every graphics engine
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } draw_state_t;

    localparam int SCREEN_W_DEFAULT  = 320;
    localparam int SCREEN_H_DEFAULT  = 240;
    localparam int TRANSPARENT_COLOR = 0;

endpackage

// File: rtl/sprite_blitter_if.sv
// rtl/sprite_blitter_if.sv - sprite memory read bus and VGA pixel write bus
interface sprite_blitter_if #(
    parameter int ADDR_W  = 15,
    parameter int COORD_W = 10,
    parameter int COLOR_W = 3
);
    logic               mem_rd;
    logic [ADDR_W-1:0]  mem_addr;
    logic [COLOR_W-1:0] mem_data;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COLOR_W-1:0] color;
    logic               write_en;

    modport master (
        output mem_rd, mem_addr, x, y, color, write_en,
        input  mem_data
    );

    modport slave (
        input  mem_rd, mem_addr, x, y, color, write_en,
        output mem_data
    );
endinterface

// File: rtl/sprite_blit_datapath.sv
// rtl/sprite_blit_datapath.sv - scan counters, address arithmetic, pixel pipeline
module sprite_blit_datapath #(
    parameter int SPRITE_W    = 32,
    parameter int SPRITE_H    = 32,
    parameter int FRAME_W     = 5,
    parameter int ADDR_W      = 15,
    parameter int COORD_W     = 10,
    parameter int COLOR_W     = 3,
    parameter int SCREEN_W    = 320,
    parameter int SCREEN_H    = 240,
    parameter int TRANSPARENT = 0
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               load,
    input  logic               run,
    input  logic [COORD_W-1:0] x_pos,
    input  logic [COORD_W-1:0] y_pos,
    input  logic [FRAME_W-1:0] frame_sel,
    input  logic               flip_x,
    input  logic               flip_y,
    output logic               last,
    sprite_blitter_if.master   bus
);
    localparam int CW = $clog2(SPRITE_W);
    localparam int RW = $clog2(SPRITE_H);

    logic [CW-1:0]      col_q, col_d;
    logic [RW-1:0]      row_q, row_d;
    logic [COORD_W-1:0] x_lat_q, x_lat_d, y_lat_q, y_lat_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic               flip_x_q, flip_x_d, flip_y_q, flip_y_d;
    logic               pix_valid_q, pix_valid_d;
    logic               in_bounds_q, in_bounds_d;
    logic [COORD_W-1:0] x_q, x_d, y_q, y_d;

    logic [CW-1:0]      scol;
    logic [RW-1:0]      srow;
    logic [COORD_W:0]   px_sum, py_sum;

    // One extra bit so off-screen pixels are clipped instead of wrapping
    assign px_sum = {1'b0, x_lat_q} + (COORD_W+1)'(col_q);
    assign py_sum = {1'b0, y_lat_q} + (COORD_W+1)'(row_q);
    assign scol   = flip_x_q ? (CW'(SPRITE_W - 1) - col_q) : col_q;
    assign srow   = flip_y_q ? (RW'(SPRITE_H - 1) - row_q) : row_q;
    assign last   = run && (col_q == CW'(SPRITE_W - 1)) && (row_q == RW'(SPRITE_H - 1));

    assign bus.mem_rd   = run;
    assign bus.mem_addr = run ? (ADDR_W'(frame_q) * ADDR_W'(SPRITE_W * SPRITE_H)
                                 + ADDR_W'(srow) * ADDR_W'(SPRITE_W)
                                 + ADDR_W'(scol)) : '0;

    // Pixel stage lines up with mem_data, which returns one cycle after the read
    assign bus.x        = x_q;
    assign bus.y        = y_q;
    assign bus.color    = pix_valid_q ? bus.mem_data : '0;
    assign bus.write_en = pix_valid_q && in_bounds_q && (bus.mem_data != COLOR_W'(TRANSPARENT));

    // Latch draw parameters on accept, step the row-major scan while running
    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        x_lat_d     = x_lat_q;
        y_lat_d     = y_lat_q;
        frame_d     = frame_q;
        flip_x_d    = flip_x_q;
        flip_y_d    = flip_y_q;
        pix_valid_d = run;
        in_bounds_d = (px_sum < (COORD_W+1)'(SCREEN_W)) && (py_sum < (COORD_W+1)'(SCREEN_H));
        x_d         = run ? px_sum[COORD_W-1:0] : x_q;
        y_d         = run ? py_sum[COORD_W-1:0] : y_q;
        if (load) begin
            col_d    = '0;
            row_d    = '0;
            x_lat_d  = x_pos;
            y_lat_d  = y_pos;
            frame_d  = frame_sel;
            flip_x_d = flip_x;
            flip_y_d = flip_y;
        end else if (run) begin
            if (col_q == CW'(SPRITE_W - 1)) begin
                col_d = '0;
                row_d = row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    // Datapath registers, cleared asynchronously so outputs drop at once on reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col_q       <= '0;
            row_q       <= '0;
            x_lat_q     <= '0;
            y_lat_q     <= '0;
            frame_q     <= '0;
            flip_x_q    <= 1'b0;
            flip_y_q    <= 1'b0;
            pix_valid_q <= 1'b0;
            in_bounds_q <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            x_lat_q     <= x_lat_d;
            y_lat_q     <= y_lat_d;
            frame_q     <= frame_d;
            flip_x_q    <= flip_x_d;
            flip_y_q    <= flip_y_d;
            pix_valid_q <= pix_valid_d;
            in_bounds_q <= in_bounds_d;
            x_q         <= x_d;
            y_q         <= y_d;
        end
    end
endmodule

// File: rtl/sprite_blitter.sv
// rtl/sprite_blitter.sv - sprite blitter top: controller FSM plus datapath
module sprite_blitter
    import sprite_blitter_pkg::*;
#(
    parameter int SPRITE_W    = 32,
    parameter int SPRITE_H    = 32,
    parameter int NUM_FRAMES  = 24,
    parameter int COORD_W     = 10,
    parameter int COLOR_W     = 3,
    parameter int SCREEN_W    = SCREEN_W_DEFAULT,
    parameter int SCREEN_H    = SCREEN_H_DEFAULT,
    parameter int TRANSPARENT = TRANSPARENT_COLOR,
    localparam int FRAME_W    = $clog2(NUM_FRAMES),
    localparam int ADDR_W     = $clog2(NUM_FRAMES * SPRITE_W * SPRITE_H)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [COORD_W-1:0] x_pos,
    input  logic [COORD_W-1:0] y_pos,
    input  logic [FRAME_W-1:0] frame_sel,
    input  logic               flip_x,
    input  logic               flip_y,
    output logic               mem_rd,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [COLOR_W-1:0] mem_data,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic [COLOR_W-1:0] color,
    output logic               writeEn,
    output logic               busy,
    output logic               done,
    output logic               err
);
    draw_state_t state_q, state_d;
    logic        err_q, err_d;
    logic        accept, last, frame_ok;

    sprite_blitter_if #(.ADDR_W(ADDR_W), .COORD_W(COORD_W), .COLOR_W(COLOR_W)) pix_bus ();

    assign pix_bus.mem_data = mem_data;
    assign mem_rd   = pix_bus.mem_rd;
    assign mem_addr = pix_bus.mem_addr;
    assign x        = pix_bus.x;
    assign y        = pix_bus.y;
    assign color    = pix_bus.color;
    assign writeEn  = pix_bus.write_en;

    assign frame_ok = {1'b0, frame_sel} < (FRAME_W+1)'(NUM_FRAMES);
    assign busy     = (state_q == RUN) || (state_q == DRAIN);
    assign done     = (state_q == DONE);
    assign err      = err_q;

    // Next state: accept only valid requests in IDLE, flag out-of-range frames
    always_comb begin
        state_d = state_q;
        err_d   = 1'b0;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (frame_ok) begin
                        accept  = 1'b1;
                        state_d = RUN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RUN:     if (last) state_d = DRAIN;
            DRAIN:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Controller state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    sprite_blit_datapath #(
        .SPRITE_W   (SPRITE_W),
        .SPRITE_H   (SPRITE_H),
        .FRAME_W    (FRAME_W),
        .ADDR_W     (ADDR_W),
        .COORD_W    (COORD_W),
        .COLOR_W    (COLOR_W),
        .SCREEN_W   (SCREEN_W),
        .SCREEN_H   (SCREEN_H),
        .TRANSPARENT(TRANSPARENT)
    ) u_datapath (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (accept),
        .run      (state_q == RUN),
        .x_pos    (x_pos),
        .y_pos    (y_pos),
        .frame_sel(frame_sel),
        .flip_x   (flip_x),
        .flip_y   (flip_y),
        .last     (last),
        .bus      (pix_bus.master)
    );
endmodule

// File: tb/tb_sprite_blitter.sv
// tb/tb_sprite_blitter.sv - directed self-checking bench for sprite_blitter
module tb_sprite_blitter;
    localparam int W = 4;
    localparam int H = 4;
    localparam int NF = 6;
    localparam int AW = 7;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic [9:0] x_pos = '0;
    logic [9:0] y_pos = '0;
    logic [2:0] frame_sel = '0;
    logic       flip_x = 1'b0;
    logic       flip_y = 1'b0;
    logic       busy, done, err;

    logic [2:0] mem [0:127];

    int checks = 0;
    int errors = 0;

    int rd_a [0:40];
    int we_a [0:40];
    int bs_a [0:40];
    int dn_a [0:40];
    int er_a [0:40];
    int ad_a [0:40];
    int x_a  [0:40];
    int y_a  [0:40];
    int co_a [0:40];
    int n_rd, n_we, n_busy, n_done, n_err, done_cyc, bad;

    sprite_blitter_if #(.ADDR_W(AW), .COORD_W(10), .COLOR_W(3)) bus ();

    sprite_blitter #(.SPRITE_W(W), .SPRITE_H(H), .NUM_FRAMES(NF)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .x_pos    (x_pos),
        .y_pos    (y_pos),
        .frame_sel(frame_sel),
        .flip_x   (flip_x),
        .flip_y   (flip_y),
        .mem_rd   (bus.mem_rd),
        .mem_addr (bus.mem_addr),
        .mem_data (bus.mem_data),
        .x        (bus.x),
        .y        (bus.y),
        .color    (bus.color),
        .writeEn  (bus.write_en),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.mem_rd) bus.mem_data <= mem[bus.mem_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Accept edge is cycle 0; samples are taken in cycles 1..40
    task automatic draw(input int xp, input int yp, input int fr, input bit fx, input bit fy,
                        input bit again);
        x_pos = 10'(xp); y_pos = 10'(yp); frame_sel = 3'(fr); flip_x = fx; flip_y = fy;
        start = 1'b1;
        tick();
        start = 1'b0;
        x_pos = 10'd777; y_pos = 10'd555; frame_sel = 3'd0; flip_x = ~fx; flip_y = ~fy;
        n_rd = 0; n_we = 0; n_busy = 0; n_done = 0; n_err = 0; done_cyc = -1;
        for (int c = 1; c <= 40; c++) begin
            rd_a[c] = int'(bus.mem_rd);
            we_a[c] = int'(bus.write_en);
            bs_a[c] = int'(busy);
            dn_a[c] = int'(done);
            er_a[c] = int'(err);
            ad_a[c] = int'(bus.mem_addr);
            x_a[c]  = int'(bus.x);
            y_a[c]  = int'(bus.y);
            co_a[c] = int'(bus.color);
            if (c <= 19) begin
                n_rd += rd_a[c]; n_we += we_a[c]; n_busy += bs_a[c];
                n_done += dn_a[c]; n_err += er_a[c];
                if (dn_a[c] == 1 && done_cyc < 0) done_cyc = c;
            end
            start = again && (c == 19);
            tick();
        end
        start = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 3'd0;
        for (int i = 0; i < 16; i++) mem[i] = 3'd5;
        for (int i = 0; i < 16; i++)
            mem[16 + i] = (i == 0 || i == 3 || i == 5 || i == 8 || i == 12 || i == 15)
                          ? 3'd0 : 3'((i % 7) + 1);
        for (int i = 0; i < 16; i++) mem[32 + i] = 3'd3;

        tick(); tick();
        chk("reset_ctrl", int'({bus.mem_rd, bus.write_en, busy, done, err}), 0);
        chk("reset_xy", int'({bus.x, bus.y}), 0);
        chk("reset_addr_color", int'({bus.mem_addr, bus.color}), 0);
        reset_n = 1'b1;
        tick();

        // Frame 0, colour 5, at (10,20); second start in the cycle after done
        draw(10, 20, 0, 1'b0, 1'b0, 1'b1);
        chk("a_writes", n_we, 16);
        chk("a_reads", n_rd, 16);
        chk("a_busy_cycles", n_busy, 17);
        chk("a_busy_c1", bs_a[1], 1);
        chk("a_busy_c17", bs_a[17], 1);
        chk("a_done_cycle", done_cyc, 18);
        chk("a_done_count", n_done, 1);
        chk("a_busy_at_done", bs_a[18], 0);
        chk("a_first_addr", ad_a[1], 0);
        chk("a_last_addr", ad_a[16], 15);
        chk("a_we_c1", we_a[1], 0);
        bad = 0;
        for (int k = 0; k < 16; k++)
            if (we_a[k + 2] != 1 || x_a[k + 2] != 10 + k % 4 || y_a[k + 2] != 20 + k / 4
                || co_a[k + 2] != 5) bad++;
        chk("a_pixel_order", bad, 0);
        chk("a_last_x_latched", x_a[17], 13);
        chk("a_b2b_busy", bs_a[20], 1);
        chk("a_b2b_done", dn_a[37], 1);
        chk("a_b2b_done_early", dn_a[36], 0);

        // Frame 2 mirrored both ways
        draw(0, 0, 2, 1'b1, 1'b1, 1'b0);
        chk("b_first_addr", ad_a[1], 47);
        chk("b_second_addr", ad_a[2], 46);
        chk("b_last_addr", ad_a[16], 32);
        chk("b_writes", n_we, 16);

        // Right-edge clipping
        draw(318, 20, 0, 1'b0, 1'b0, 1'b0);
        chk("c_writes", n_we, 8);
        bad = 0;
        for (int c = 1; c <= 19; c++)
            if (we_a[c] == 1 && x_a[c] != 318 && x_a[c] != 319) bad++;
        chk("c_clip_cols", bad, 0);
        chk("c_done_cycle", done_cyc, 18);

        // Frame 1 with six transparent pixels
        draw(0, 0, 1, 1'b0, 1'b0, 1'b0);
        chk("d_writes", n_we, 10);
        chk("d_done_cycle", done_cyc, 18);
        chk("d_busy_cycles", n_busy, 17);
        chk("d_we_c2", we_a[2], 0);
        chk("d_color_c3", co_a[3], 2);
        chk("d_x_c3", x_a[3], 1);

        // Out-of-range frame request
        draw(5, 5, NF, 1'b0, 1'b0, 1'b0);
        chk("e_err_c1", er_a[1], 1);
        chk("e_err_count", n_err, 1);
        chk("e_reads", n_rd, 0);
        chk("e_busy", n_busy, 0);
        chk("e_done", n_done, 0);

        // Reset in cycle 7 of a draw
        x_pos = 10'd10; y_pos = 10'd20; frame_sel = 3'd0; flip_x = 1'b0; flip_y = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 7; c++) tick();
        chk("f_x_before_reset", int'(bus.x), 11);
        reset_n = 1'b0;
        #1;
        chk("f_reset_ctrl", int'({bus.mem_rd, bus.write_en, busy, done, err}), 0);
        chk("f_reset_xy", int'({bus.x, bus.y}), 0);
        chk("f_reset_addr_color", int'({bus.mem_addr, bus.color}), 0);
        bad = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            bad += int'(bus.write_en) + int'(busy);
        end
        chk("f_held_quiet", bad, 0);
        reset_n = 1'b1;
        tick();
        draw(10, 20, 0, 1'b0, 1'b0, 1'b0);
        chk("f_redraw_writes", n_we, 16);
        chk("f_redraw_done", done_cyc, 18);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
